// File: rtl/sprite_pkg.sv
// sprite_pkg: shared screen constants and pixel types for the sprite layers
package sprite_pkg;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  typedef logic [9:0] coord_t;
  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;
endpackage

// File: rtl/sprite_anim_ctrl.sv
// sprite_anim_ctrl: once-per-frame latch of position/flip and animation frame stepping
module sprite_anim_ctrl
  import sprite_pkg::*;
#(
  parameter int FRAMES   = 4,
  parameter int ANIM_DIV = 8,
  parameter int LATCH_Y  = 480,
  parameter int FW       = FRAMES > 1 ? $clog2(FRAMES) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  coord_t        draw_x,
  input  coord_t        draw_y,
  input  coord_t        pos_x,
  input  coord_t        pos_y,
  input  logic          flip_x,
  input  logic          anim_en,
  output logic [FW-1:0] frame,
  output coord_t        pos_x_l,
  output coord_t        pos_y_l,
  output logic          flip_l
);
  localparam int DW = ANIM_DIV > 1 ? $clog2(ANIM_DIV) : 1;
  logic [DW-1:0] div_cnt_d, div_cnt_q;
  logic [FW-1:0] frame_d, frame_q;
  coord_t pos_x_d, pos_x_q, pos_y_d, pos_y_q;
  logic flip_d, flip_q, upd, step;
  always_comb begin
    upd = draw_y == coord_t'(LATCH_Y) && draw_x == '0;
    step = upd && anim_en && div_cnt_q == DW'(ANIM_DIV - 1);
    div_cnt_d = (upd && anim_en) ? (step ? '0 : div_cnt_q + 1'b1) : div_cnt_q;
    frame_d = step ? (frame_q == FW'(FRAMES - 1) ? '0 : frame_q + 1'b1) : frame_q;
    pos_x_d = upd ? pos_x : pos_x_q;
    pos_y_d = upd ? pos_y : pos_y_q;
    flip_d = upd ? flip_x : flip_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q <= '0;
      frame_q <= '0;
      pos_x_q <= '0;
      pos_y_q <= '0;
      flip_q <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      frame_q <= frame_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      flip_q <= flip_d;
    end
  end
  assign frame = frame_q;
  assign pos_x_l = pos_x_q;
  assign pos_y_l = pos_y_q;
  assign flip_l = flip_q;
endmodule

// File: rtl/sprite_layer.sv
// sprite_layer: positioned, scaled, mirrored, animated sprite over a 3-stage ROM/palette pipeline
module sprite_layer
  import sprite_pkg::*;
#(
  parameter int SPR_W      = 20,
  parameter int SPR_H      = 20,
  parameter int FRAMES     = 4,
  parameter int SCALE_LOG2 = 1,
  parameter int IDX_W      = 5,
  parameter int TRANSP_IDX = 0,
  parameter int ANIM_DIV   = 8,
  parameter int LATCH_Y    = 480,
  parameter int ADDR_W     = $clog2(FRAMES * SPR_W * SPR_H)
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  coord_t            DrawX,
  input  coord_t            DrawY,
  input  logic              blank,
  input  coord_t            pos_x,
  input  coord_t            pos_y,
  input  logic              flip_x,
  input  logic              anim_en,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [IDX_W-1:0]  rom_q,
  output logic [IDX_W-1:0]  pal_index,
  input  logic [3:0]        pal_red,
  input  logic [3:0]        pal_green,
  input  logic [3:0]        pal_blue,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              opaque
);
  localparam int FW = FRAMES > 1 ? $clog2(FRAMES) : 1;
  logic [FW-1:0] frame;
  coord_t pos_x_l, pos_y_l;
  logic flip_l, hit, hit1_q, blank1_q, hit2_q, blank2_q, opaque_d, opaque_q;
  logic [10:0] dx, dy, col, row;
  logic [ADDR_W-1:0] rom_address_d, rom_address_q;
  rgb444_t rgb_d, rgb_q;
  sprite_anim_ctrl #(.FRAMES(FRAMES), .ANIM_DIV(ANIM_DIV), .LATCH_Y(LATCH_Y), .FW(FW)) u_anim (
    .clk(vga_clk), .reset(reset), .draw_x(DrawX), .draw_y(DrawY),
    .pos_x(pos_x), .pos_y(pos_y), .flip_x(flip_x), .anim_en(anim_en),
    .frame(frame), .pos_x_l(pos_x_l), .pos_y_l(pos_y_l), .flip_l(flip_l)
  );
  // 11-bit differences: bit 10 set means the pixel is left of / above the sprite, so no wrap-around
  always_comb begin
    dx = {1'b0, DrawX} - {1'b0, pos_x_l};
    dy = {1'b0, DrawY} - {1'b0, pos_y_l};
    hit = !dx[10] && !dy[10] && dx < 11'(SPR_W << SCALE_LOG2) && dy < 11'(SPR_H << SCALE_LOG2);
    row = dy >> SCALE_LOG2;
    col = flip_l ? 11'(SPR_W - 1) - (dx >> SCALE_LOG2) : dx >> SCALE_LOG2;
    rom_address_d = hit ? ADDR_W'(32'(frame) * SPR_H * SPR_W + 32'(row) * SPR_W + 32'(col)) : '0;
    opaque_d = blank2_q && hit2_q && rom_q != IDX_W'(TRANSP_IDX);
    rgb_d = opaque_d ? {pal_red, pal_green, pal_blue} : '0;
  end
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      rom_address_q <= '0;
      hit1_q <= 1'b0;
      blank1_q <= 1'b0;
      hit2_q <= 1'b0;
      blank2_q <= 1'b0;
      rgb_q <= '0;
      opaque_q <= 1'b0;
    end else begin
      rom_address_q <= rom_address_d;
      hit1_q <= hit;
      blank1_q <= blank;
      hit2_q <= hit1_q;
      blank2_q <= blank1_q;
      rgb_q <= rgb_d;
      opaque_q <= opaque_d;
    end
  end
  assign rom_address = rom_address_q;
  assign pal_index = rom_q;
  assign red = rgb_q.r;
  assign green = rgb_q.g;
  assign blue = rgb_q.b;
  assign opaque = opaque_q;
endmodule

// File: tb/tb_sprite_layer.sv
// tb_sprite_layer: directed pixels with a scoreboard checking rom_address (1 edge) and colour (3 edges)
module tb_sprite_layer;
  logic vga_clk = 1'b0, reset = 1'b1, blank = 1'b0, flip_x = 1'b0, anim_en = 1'b0, opaque;
  logic [9:0] DrawX = '0, DrawY = '0, pos_x = 10'd100, pos_y = 10'd50;
  logic [10:0] rom_address;
  logic [4:0] rom_q = '0, pal_index;
  logic [3:0] pal_red, pal_green, pal_blue, red, green, blue;
  int tests = 0, fails = 0;
  bit chk = 1'b0, v1 = 1'b0, v2 = 1'b0, v3 = 1'b0;
  logic [10:0] aq[$];
  logic [12:0] pq[$];
  sprite_layer dut (
    .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .pos_x(pos_x), .pos_y(pos_y), .flip_x(flip_x), .anim_en(anim_en),
    .rom_address(rom_address), .rom_q(rom_q), .pal_index(pal_index),
    .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
    .red(red), .green(green), .blue(blue), .opaque(opaque)
  );
  always #5 vga_clk = ~vga_clk;
  // ROM image: index is zero (transparent) exactly when address[4:0] == 9
  function automatic logic [4:0] rom_idx(input logic [10:0] a);
    return a[4:0] ^ 5'd9;
  endfunction
  function automatic logic [11:0] pal(input logic [4:0] i);
    return {i[3:0], i[4:1], ~i[3:0]};
  endfunction
  assign {pal_red, pal_green, pal_blue} = pal(pal_index);
  always @(posedge vga_clk) rom_q <= rom_idx(rom_address);
  always @(posedge vga_clk) {v3, v2, v1} <= {v2, v1, chk};
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  always @(negedge vga_clk) begin
    if (v1) begin
      if (aq.size() == 0) begin
        tests++; fails++;
        $display("FAIL addr_queue: got empty expected entry");
      end else check("rom_address", 32'(rom_address), 32'(aq.pop_front()));
    end
    if (v3) begin
      if (pq.size() == 0) begin
        tests++; fails++;
        $display("FAIL pixel_queue: got empty expected entry");
      end else check("opaque_rgb", 32'({opaque, red, green, blue}), 32'(pq.pop_front()));
    end
  end
  // ea < 0 means the pixel misses the sprite box
  task automatic pix(input int x, input int y, input bit b, input bit c, input int ea);
    logic [10:0] a;
    logic op;
    @(negedge vga_clk);
    DrawX = 10'(x); DrawY = 10'(y); blank = b; chk = c;
    a = ea < 0 ? 11'd0 : 11'(ea);
    op = b && ea >= 0 && rom_idx(a) != 5'd0;
    if (c) begin
      aq.push_back(a);
      pq.push_back(op ? {1'b1, pal(rom_idx(a))} : 13'd0);
    end
  endtask
  task automatic vsync();
    pix(0, 480, 0, 0, 0);
  endtask
  initial begin
    repeat (3) @(negedge vga_clk);
    check("rst_opaque", 32'(opaque), 0);
    check("rst_rgb", 32'({red, green, blue}), 0);
    check("rst_addr", 32'(rom_address), 0);
    reset = 1'b0;
    vsync();
    for (int x = 99; x <= 140; x++) pix(x, 50, 1, 1, (x >= 100 && x <= 139) ? (x - 100) >> 1 : -1);
    pix(110, 50, 0, 1, 5);
    flip_x = 1'b1; vsync();
    pix(100, 50, 1, 1, 19); pix(139, 50, 1, 1, 0);
    flip_x = 1'b0; vsync();
    anim_en = 1'b1;
    pix(100, 50, 1, 1, 0);
    for (int k = 1; k <= 4; k++) begin
      repeat (8) vsync();
      pix(100, 50, 1, 1, (k % 4) * 400);
    end
    repeat (4) vsync();
    anim_en = 1'b0; repeat (8) vsync();
    pix(100, 50, 1, 1, 0);
    anim_en = 1'b1; repeat (4) vsync();
    pix(100, 50, 1, 1, 400);
    anim_en = 1'b0;
    pix(0, 200, 1, 0, 0);
    pos_x = 10'd300;
    pix(100, 60, 1, 1, 500); pix(300, 60, 1, 1, -1);
    vsync();
    pix(300, 60, 1, 1, 500); pix(100, 60, 1, 1, -1); pix(300, 50, 1, 1, 400);
    pos_x = 10'd630; pos_y = 10'd470; vsync();
    pix(630, 470, 1, 1, 400); pix(639, 479, 1, 1, 484);
    pix(9, 470, 1, 1, -1); pix(0, 479, 1, 1, -1); pix(629, 470, 1, 1, -1);
    repeat (3) pix(635, 475, 1, 0, 0);
    @(negedge vga_clk) reset = 1'b1;
    @(negedge vga_clk);
    check("midline_rst_opaque", 32'(opaque), 0);
    check("midline_rst_rgb", 32'({red, green, blue}), 0);
    check("midline_rst_addr", 32'(rom_address), 0);
    reset = 1'b0;
    pix(5, 0, 1, 1, 2);
    repeat (4) pix(0, 0, 0, 0, 0);
    check("queues_drained", 32'(aq.size() + pq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sprite_layer.md
# sprite_layer

Parametrised sprite renderer for the VGA path: draws one animated, optionally mirrored sprite of SPR_W×SPR_H texels at a movable screen position, with power-of-two scaling and a transparent colour index. Sits between the VGA controller (DrawX/DrawY/blank) and the final colour mux. It drives an external synchronous sprite ROM and an external combinational palette. It supersedes the full-screen single-image drawers: position, flip, frame animation and an opacity flag are added so several layers can be composited.

## Interface
- SPR_W, 20, sprite width in texels
- SPR_H, 20, sprite height in texels
- FRAMES, 4, animation frames stored back-to-back in ROM
- SCALE_LOG2, 1, each texel covers 2^SCALE_LOG2 × 2^SCALE_LOG2 pixels
- IDX_W, 5, ROM colour-index width
- TRANSP_IDX, 0, index treated as transparent
- ANIM_DIV, 8, video frames per animation step (≥1)
- LATCH_Y, 480, DrawY line where position/flip/frame update (first vblank line)
- ADDR_W, $clog2(FRAMES*SPR_W*SPR_H), ROM address width (11 at defaults)
- vga_clk  in  1  pixel clock; all logic on posedge
- reset  in  1  synchronous, active-high
- DrawX, DrawY  in  10 each  current pixel coordinates
- blank  in  1  high = active display region
- pos_x, pos_y  in  10 each  requested top-left screen position
- flip_x  in  1  1 = mirror horizontally (sprite faces left)
- anim_en  in  1  1 = advance frames; 0 = hold current frame
- rom_address  out  ADDR_W  texel address to sprite ROM
- rom_q  in  IDX_W  ROM data, valid one vga_clk after rom_address
- pal_index  out  IDX_W  palette lookup index (= rom_q)
- pal_red, pal_green, pal_blue  in  4 each  palette colour for pal_index (combinational)
- red, green, blue  out  4 each  pixel colour
- opaque  out  1  1 = this layer covers the pixel

## Operation
- Update event: DrawY==LATCH_Y && DrawX==0. On it: pos_x_l, pos_y_l, flip_l ← pos_x, pos_y, flip_x. Mid-frame input changes are never visible (no tearing).
- Animation: div_cnt counts update events 0..ANIM_DIV-1. At wrap, if anim_en, frame ← (frame+1) mod FRAMES. With anim_en=0, frame and div_cnt hold.
- Hit test uses 11-bit signed arithmetic: dx = DrawX − pos_x_l, dy = DrawY − pos_y_l. hit = 0 ≤ dx < SPR_W<<SCALE_LOG2 and 0 ≤ dy < SPR_H<<SCALE_LOG2. Sprites partly off the right/bottom edge clip; no wrap-around to the left/top.
- Texel: col = dx>>SCALE_LOG2, row = dy>>SCALE_LOG2. If flip_l, col ← SPR_W−1−col.
- rom_address = frame·SPR_W·SPR_H + row·SPR_W + col. On a miss it is don't-care but forced to 0.
- Output: if blank_d2 && hit_d2 && rom_q≠TRANSP_IDX, then rgb ← pal_*, opaque ← 1. Otherwise rgb ← 0, opaque ← 0.
- Reset values: red/green/blue 0, opaque 0, rom_address 0, frame 0, div_cnt 0, latched pos 0, flip_l 0, pipeline valid flags 0.

## Timing
- Stage 0, edge k: register rom_address, hit_d1, blank_d1 from DrawX/DrawY sampled at edge k.
- Stage 1, edge k+1: ROM registers rom_q; hit_d2, blank_d2 register.
- Stage 2, edge k+2: red/green/blue/opaque register.
- Fixed latency: 3 edges from coordinate to colour. The VGA controller delays hs/vs by 3 to match.
- Frame/position change takes effect on the first pixel after the update event. Pipeline flags for pixels already in flight use their own captured hit.
- Reset asserted mid-line: all outputs 0 on the next edge. Normal output resumes 3 cycles after release. Latched pos reads 0 until the next update event.
- ANIM_DIV=1: frame advances on every update event.

## Structure
- Shared package sprite_pkg: SCREEN_W=640, SCREEN_H=480, coordinate type coord_t (10 bit), rgb444 struct.
- Sub-module sprite_anim_ctrl: update-event detect, position/flip latch, div_cnt and frame counter. Outputs frame, pos_x_l, pos_y_l, flip_l.
- Top sprite_layer: hit test, address computation, 3-stage pipeline, output mux.

## Test plan
- Defaults, pos=(100,50), frame 0, no flip. At DrawX=100..139, DrawY=50, ROM index≠0 → opaque=1 three cycles later. DrawX=99 and DrawX=140 → opaque=0, rgb 0.
- flip_x=1 latched. Pixel (100,50) → rom_address = 19. Pixel (139,50) → rom_address = 0.
- anim_en=1, ANIM_DIV=8 → frame steps every 8 update events and wraps 3→0. Pixel (100,50) address sequence is 0, 400, 800, 1200, 0. Dropping anim_en holds the frame.
- pos_x changed at DrawY=200 mid-frame → rendering unchanged until line 480. New position is used from the next frame's line 0.
- rom_q = TRANSP_IDX inside the box → opaque=0, rgb=0. blank=0 inside the box → opaque=0.
- pos=(630,470): clips at x=639/y=479, nothing drawn at x<10. Reset pulse mid-line → outputs 0 next edge, frame 0.
